// File: rtl/cpu_pkg.sv
// Shared fetch-stage types and constants.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_DISCARD
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and the I-cache.
interface if_fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_data_i;

  modport master (output imem_req_o, output imem_addr_o,
                  input  imem_ack_i, input  imem_data_i);
  modport slave  (input  imem_req_o, input  imem_addr_o,
                  output imem_ack_i, output imem_data_i);

endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// One-entry PC+instruction buffer used while IF/ID is stalled.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      instr_o <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      pc_o    <= pc_i;
      instr_o <= instr_i;
    end else if (clear_i) begin
      valid_o <= 1'b0;
      pc_o    <= '0;
      instr_o <= '0;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues I-memory requests, buffers
// returned instructions across stalls and handles branch redirects.
module if_fetch_unit
  import cpu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   stall_i,
  input  logic                   mem_stall_i,
  input  logic                   branch_taken_i,
  input  logic [XLEN-1:0]        branch_target_i,
  if_fetch_unit_if.master        imem,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        instr_o,
  output logic                   valid_o,
  output logic                   bubble_o
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q, req_pc_q, pc_inc, target;
  logic            req_q, adv, hold_load, hold_clear, hold_vld;
  logic [XLEN-1:0] hold_pc, hold_instr;

  assign adv    = ~stall_i & ~mem_stall_i;
  assign pc_inc = pc_q + XLEN'(4);
  assign target = branch_target_i & ~XLEN'(3);

  assign hold_load  = (state == S_FETCH) & imem.imem_ack_i & ~adv & ~branch_taken_i;
  assign hold_clear = (state == S_HOLD) & (branch_taken_i | adv);

  fetch_hold_buf u_hold (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (req_pc_q),
    .instr_i (imem.imem_data_i),
    .valid_o (hold_vld),
    .pc_o    (hold_pc),
    .instr_o (hold_instr)
  );

  // The buffer is valid exactly while the FSM sits in S_HOLD.
  assign valid_o  = ~branch_taken_i & (((state == S_FETCH) & imem.imem_ack_i) | hold_vld);
  assign bubble_o = ~valid_o;

  always_comb begin
    pc_o    = pc_q;
    instr_o = NOP_INSTR;
    if (valid_o) begin
      if (hold_vld) begin
        pc_o    = hold_pc;
        instr_o = hold_instr;
      end else begin
        pc_o    = req_pc_q;
        instr_o = imem.imem_data_i;
      end
    end
  end

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = req_pc_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      req_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
          req_q <= 1'b1;
        end
        S_FETCH: begin
          if (branch_taken_i) begin
            pc_q <= target;
            if (imem.imem_ack_i) req_pc_q <= target;
            else                 state    <= S_DISCARD;
          end else if (imem.imem_ack_i) begin
            pc_q <= pc_inc;
            if (adv) begin
              req_pc_q <= pc_inc;
            end else begin
              state <= S_HOLD;
              req_q <= 1'b0;
            end
          end
        end
        S_HOLD: begin
          if (branch_taken_i) begin
            pc_q     <= target;
            req_pc_q <= target;
            state    <= S_FETCH;
            req_q    <= 1'b1;
          end else if (adv) begin
            req_pc_q <= pc_q;
            state    <= S_FETCH;
            req_q    <= 1'b1;
          end
        end
        S_DISCARD: begin
          // Stale address stays on the bus until its ack retires it.
          if (branch_taken_i) begin
            pc_q <= target;
            if (imem.imem_ack_i) begin
              req_pc_q <= target;
              state    <= S_FETCH;
            end
          end else if (imem.imem_ack_i) begin
            req_pc_q <= pc_q;
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed pipeline scenarios, randomized
// stalls/branches/memory latency, and an asynchronous reset mid-request.
module tb_if_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        stall_i, mem_stall_i, branch_taken_i;
  logic [31:0] branch_target_i;
  logic [31:0] pc_o, instr_o;
  logic        valid_o, bubble_o;

  if_fetch_unit_if imem_bus();

  if_fetch_unit dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .stall_i         (stall_i),
    .mem_stall_i     (mem_stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem            (imem_bus),
    .pc_o            (pc_o),
    .instr_o         (instr_o),
    .valid_o         (valid_o),
    .bubble_o        (bubble_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct packed {
    bit        st, ms, br, ack, ereq;
    bit [31:0] tgt, eaddr;
  } row_t;

  exp_t        exp_q[$];
  logic [31:0] next_pc;
  int          total = 0;
  int          bad = 0;
  int          consumed = 0;
  bit          mon_en = 1'b0;

  // Program image: an odd multiplier keeps every address's word distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Drives one cycle of inputs; memory acks only a live request. Architectural
  // model: delivered PCs run sequentially, a taken branch restarts them at the target.
  task automatic apply(input bit st, input bit ms, input bit br,
                       input logic [31:0] tgt, input bit ack_en);
    stall_i         = st;
    mem_stall_i     = ms;
    branch_taken_i  = br;
    branch_target_i = tgt;
    imem_bus.imem_ack_i  = imem_bus.imem_req_o & ack_en;
    imem_bus.imem_data_i = imem_bus.imem_ack_i ? mem_word(imem_bus.imem_addr_o) : $urandom;
    if (br) begin
      exp_q.delete();
      next_pc = tgt & 32'hFFFF_FFFC;
    end
    while (exp_q.size() < 4) begin
      exp_q.push_back('{next_pc, mem_word(next_pc)});
      next_pc = next_pc + 32'd4;
    end
  endtask

  // Monitor: every instruction IF/ID actually samples must be the next one in program order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        check("bubble_eq_not_valid", {31'b0, bubble_o}, {31'b0, ~valid_o});
        if (!valid_o) begin
          check("nop_when_invalid", instr_o, NOP_INSTR);
        end else if (!stall_i && !mem_stall_i) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got pc=%h want none t=%0t", pc_o, $time);
          end else begin
            e = exp_q.pop_front();
            check("pc", pc_o, e.pc);
            check("instr", instr_o, e.instr);
            consumed++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  row_t script [0:17] = '{
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0},    // IDLE
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h4},
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h8},    // ack 8 while stalled
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0},
    '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0},    // release: 8 delivered
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'hC},
    '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40,  32'h10},   // branch while 10 in flight
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   32'h10},
    '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,   32'h10},
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h10},   // stale ack dropped
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h40},
    '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h80,  32'h44},   // branch with ack
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h80},
    '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h84},   // mem stall -> hold
    '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0},    // branch from hold
    '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,   32'h100}
  };

  initial begin
    int          base;
    bit          st, ms, br;
    logic [31:0] tgt;

    rst_n_i = 1'b0;
    stall_i = 1'b0;
    mem_stall_i = 1'b0;
    branch_taken_i = 1'b0;
    branch_target_i = 32'h0;
    imem_bus.imem_ack_i = 1'b0;
    imem_bus.imem_data_i = 32'h0;
    next_pc = RESET_PC;

    repeat (3) @(negedge clk);
    #4;
    check("rst_req", {31'b0, imem_bus.imem_req_o}, 32'd0);
    check("rst_addr", imem_bus.imem_addr_o, RESET_PC);
    check("rst_pc", pc_o, RESET_PC);
    check("rst_instr", instr_o, NOP_INSTR);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_bubble", {31'b0, bubble_o}, 32'd1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst_n_i = 1'b1;
        mon_en  = 1'b1;
      end
      apply(script[i].st, script[i].ms, script[i].br, script[i].tgt, script[i].ack);
      #4;
      check("dir_req", {31'b0, imem_bus.imem_req_o}, {31'b0, script[i].ereq});
      if (script[i].ereq) check("dir_addr", imem_bus.imem_addr_o, script[i].eaddr);
      if (script[i].br) check("dir_branch_bubble", {31'b0, valid_o}, 32'd0);
    end

    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      st = ($urandom % 5) == 0;
      ms = ($urandom % 10) == 0;
      br = ($urandom % 12) == 0;
      tgt = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                  : ($urandom & 32'h0000_3FFF);
      apply(st, ms, br, tgt, ($urandom % 3) != 0);
    end
    @(negedge clk);
    total++;
    if (consumed - base < 300) begin
      bad++;
      $display("FAIL random_progress: got=%0d want>=300", consumed - base);
    end

    // Redirect to 24, then pull reset while that request is still waiting.
    apply(1'b0, 1'b0, 1'b1, 32'h24, 1'b1);
    @(negedge clk);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    check("mid_req", {31'b0, imem_bus.imem_req_o}, 32'd1);
    check("mid_addr", imem_bus.imem_addr_o, 32'h24);
    mon_en  = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("async_rst_req", {31'b0, imem_bus.imem_req_o}, 32'd0);
    check("async_rst_addr", imem_bus.imem_addr_o, RESET_PC);
    check("async_rst_pc", pc_o, RESET_PC);
    check("async_rst_instr", instr_o, NOP_INSTR);
    check("async_rst_bubble", {31'b0, bubble_o}, 32'd1);
    exp_q.delete();
    next_pc = RESET_PC;

    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    base    = consumed;
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    end
    @(negedge clk);
    check("restart_throughput", consumed - base, 32'd19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
